// File: rtl/uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver
//
// 8N1 UART receiver producing one byte per frame. The raw RX pin is
// synchronised, a falling edge arms the start-bit check at mid-bit, each data
// bit is sampled at its centre (LSB first) and the stop bit decides whether
// the byte is delivered or dropped as a framing error.
//
// Ports
//   system_clock    in   1  system clock, rising edge
//   system_reset_n  in   1  asynchronous reset, active low
//   uart_rxd        in   1  raw serial input, asynchronous, idle high
//   data_received   out  8  last correctly framed byte
//   received_flag   out  1  one-cycle pulse: data_received updated this cycle
//   framing_error   out  1  one-cycle pulse: stop bit was low, byte dropped
//   rx_busy         out  1  high whenever the receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_byte_receiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       system_clock,
    input  logic       system_reset_n,
    input  logic       uart_rxd,
    output logic [7:0] data_received,
    output logic       received_flag,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchroniser and edge history
    logic             sync1_q;
    logic             rxS_q;
    logic             rxSDly_q;
    logic [2:0]       primed_q;

    // Receiver FSM
    state_t           state_q;
    logic [CNT_W-1:0] baudCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic             stopPend_q;
    logic             stopBit_q;

    // Registered outputs
    logic [7:0]       data_q;
    logic             flag_q;
    logic             ferr_q;
    logic             busy_q;

    logic             fallEdge;

    // Two-flop synchroniser on the raw pin plus one history flop for edge
    // detection. The flops reset high so the line reads idle; primed_q fills
    // with ones over three clocks so that an edge is only believed once both
    // rxS_q and rxSDly_q hold real line samples. A line that is already low
    // when reset is released therefore never looks like a falling edge.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync1_q  <= 1'b1;
            rxS_q    <= 1'b1;
            rxSDly_q <= 1'b1;
            primed_q <= 3'b000;
        end else begin
            sync1_q  <= uart_rxd;
            rxS_q    <= sync1_q;
            rxSDly_q <= rxS_q;
            primed_q <= {primed_q[1:0], 1'b1};
        end
    end

    assign fallEdge = primed_q[2] & ~rxS_q & rxSDly_q;

    // Frame FSM with registered outputs. The stop bit is captured at
    // mid-stop-bit and the FSM drops back to IDLE right away, so a start bit
    // that follows with no idle gap is still caught. The captured stop level
    // is turned into received_flag or framing_error on the following edge;
    // that pending slot is independent of the state so a new frame may
    // already be starting while the previous result is published.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= 3'd0;
            shift_q    <= 8'h00;
            stopPend_q <= 1'b0;
            stopBit_q  <= 1'b0;
            data_q     <= 8'h00;
            flag_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            flag_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stopPend_q <= 1'b0;

            if (stopPend_q) begin
                if (stopBit_q) begin
                    data_q <= shift_q;
                    flag_q <= 1'b1;
                end else begin
                    ferr_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (fallEdge) begin
                        state_q   <= START;
                        baudCnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (baudCnt_q == HALF_LAST) begin
                        if (rxS_q) begin
                            // Line went back high before mid-start: glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            baudCnt_q <= '0;
                            bitIdx_q  <= 3'd0;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CNT_ONE;
                    end
                end

                DATA: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        // Right shift: the first (LSB) bit ends up in [0].
                        shift_q   <= {rxS_q, shift_q[7:1]};
                        baudCnt_q <= '0;
                        bitIdx_q  <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CNT_ONE;
                    end
                end

                STOP: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        stopBit_q  <= rxS_q;
                        stopPend_q <= 1'b1;
                        state_q    <= IDLE;
                        baudCnt_q  <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        baudCnt_q <= baudCnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_received = data_q;
    assign received_flag = flag_q;
    assign framing_error = ferr_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_receiver
//
// Directed bench for uart_byte_receiver at 50 MHz / 115200 baud. Frames are
// bit-banged onto uart_rxd; a monitor collects every received byte and
// counts flag/error pulses, and the main sequence compares those against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_uart_byte_receiver;

    localparam int BAUD_DIV = 50_000_000 / 115200;   // 434
    localparam int HALF_DIV = BAUD_DIV / 2;          // 217
    localparam int BIT_FAST = 425;                   // about +2 % baud
    localparam int BIT_SLOW = 443;                   // about -2 % baud
    localparam int STOP_LAT = HALF_DIV + 9 * BAUD_DIV;

    logic       clk;
    logic       rstN;
    logic       rxd;
    logic [7:0] dataReceived;
    logic       receivedFlag;
    logic       framingError;
    logic       rxBusy;

    int         cyc;
    int         startCyc;
    int         lastFlagCyc;
    int         flagCount;
    int         errCount;
    int         pulseViol;
    bit         prevPulse;
    logic [7:0] rxQ[$];

    int         checkCount;
    int         passCount;
    int         failCount;

    uart_byte_receiver #(
        .CLK_FREQ (50_000_000),
        .BAUD_RATE(115200)
    ) dut (
        .system_clock  (clk),
        .system_reset_n(rstN),
        .uart_rxd      (rxd),
        .data_received (dataReceived),
        .received_flag (receivedFlag),
        .framing_error (framingError),
        .rx_busy       (rxBusy)
    );

    // 50 MHz clock and a free-running cycle counter for latency measurement.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor, sampling on the falling edge: records delivered bytes, counts
    // pulses and flags any flag/error overlap or back-to-back pulse.
    always @(negedge clk) begin
        if (!rstN) begin
            prevPulse = 1'b0;
        end else begin
            if (receivedFlag) begin
                rxQ.push_back(dataReceived);
                flagCount++;
                lastFlagCyc = cyc;
            end
            if (framingError) errCount++;
            if ((receivedFlag && framingError) ||
                ((receivedFlag || framingError) && prevPulse)) pulseViol++;
            prevPulse = receivedFlag || framingError;
        end
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame, LSB first, starting at the current falling edge.
    // The stop level is left on the line so another frame can follow at once.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int bitClk);
        rxd = 1'b0;
        startCyc = cyc;
        repeat (bitClk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bitClk) @(negedge clk);
        end
        rxd = stopBit;
        repeat (bitClk) @(negedge clk);
    endtask

    task automatic idleLine(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    logic [7:0] frameA5;
    int         flagsBefore;
    int         errsBefore;
    int         qBase;
    int         busyCycles;
    bit         busySeen;
    bit         busyFell;

    initial begin
        checkCount  = 0;
        passCount   = 0;
        failCount   = 0;
        flagCount   = 0;
        errCount    = 0;
        pulseViol   = 0;
        lastFlagCyc = 0;
        startCyc    = 0;
        cyc         = 0;
        rstN        = 1'b0;
        rxd         = 1'b1;

        // Reset values
        repeat (5) @(negedge clk);
        checkOutput("reset_data", 32'(dataReceived), 32'h00);
        checkOutput("reset_flag", 32'(receivedFlag), 32'h0);
        checkOutput("reset_ferr", 32'(framingError), 32'h0);
        checkOutput("reset_busy", 32'(rxBusy), 32'h0);

        // Line already low when reset is released: no frame may start
        rxd = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (2 * BAUD_DIV) @(negedge clk);
        checkOutput("lowreset_busy", 32'(rxBusy), 32'h0);
        checkOutput("lowreset_pulses", 32'(flagCount + errCount), 32'h0);
        idleLine(BAUD_DIV);

        // Test 1: single frame 0x41
        qBase = rxQ.size();
        applyStimulus(8'h41, 1'b1, BAUD_DIV);
        idleLine(BAUD_DIV);
        checkOutput("t1_flags", 32'(flagCount), 32'd1);
        checkOutput("t1_data", 32'(dataReceived), 32'h41);
        checkOutput("t1_errs", 32'(errCount), 32'd0);
        checkOutput("t1_latency",
                    32'((lastFlagCyc - startCyc >= STOP_LAT + 1) &&
                        (lastFlagCyc - startCyc <= STOP_LAT + 6)), 32'd1);
        checkOutput("t1_busy_idle", 32'(rxBusy), 32'h0);

        // Test 2: 0x2B then 0x23 with no idle bits between frames
        qBase = rxQ.size();
        applyStimulus(8'h2B, 1'b1, BAUD_DIV);
        applyStimulus(8'h23, 1'b1, BAUD_DIV);
        idleLine(BAUD_DIV);
        checkOutput("t2_flags", 32'(flagCount), 32'd3);
        checkOutput("t2_first", 32'(rxQ.size() > qBase ? rxQ[qBase] : 8'hxx), 32'h2B);
        checkOutput("t2_second", 32'(rxQ.size() > qBase + 1 ? rxQ[qBase + 1] : 8'hxx), 32'h23);

        // Test 3: 100-clock low glitch on an idle line
        flagsBefore = flagCount;
        errsBefore  = errCount;
        busySeen    = 1'b0;
        busyFell    = 1'b0;
        busyCycles  = 0;
        rxd = 1'b0;
        for (int i = 0; i < 1000 && !busyFell; i++) begin
            if (i == 100) rxd = 1'b1;
            @(negedge clk);
            busyCycles++;
            if (rxBusy) busySeen = 1'b1;
            else if (busySeen) busyFell = 1'b1;
        end
        rxd = 1'b1;
        checkOutput("t3_busy_rose", 32'(busySeen), 32'd1);
        checkOutput("t3_busy_fell_in_time",
                    32'(busyFell && (busyCycles <= HALF_DIV + 4)), 32'd1);
        idleLine(2 * BAUD_DIV);
        checkOutput("t3_no_flag", 32'(flagCount - flagsBefore), 32'd0);
        checkOutput("t3_no_err", 32'(errCount - errsBefore), 32'd0);

        // Test 4: 0x55 with a low stop bit
        flagsBefore = flagCount;
        errsBefore  = errCount;
        applyStimulus(8'h55, 1'b0, BAUD_DIV);
        idleLine(BAUD_DIV);
        checkOutput("t4_err", 32'(errCount - errsBefore), 32'd1);
        checkOutput("t4_no_flag", 32'(flagCount - flagsBefore), 32'd0);
        checkOutput("t4_data_kept", 32'(dataReceived), 32'h23);

        // Test 5: reset in the middle of bit 4 of 0xA5, then 0x3C
        frameA5 = 8'hA5;
        rxd = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = frameA5[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rxd = frameA5[4];
        repeat (HALF_DIV) @(negedge clk);
        checkOutput("t5_busy_before_reset", 32'(rxBusy), 32'h1);
        rstN = 1'b0;
        #1;
        checkOutput("t5_reset_data", 32'(dataReceived), 32'h00);
        checkOutput("t5_reset_busy", 32'(rxBusy), 32'h0);
        checkOutput("t5_reset_flag", 32'(receivedFlag), 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        idleLine(2 * BAUD_DIV);
        flagsBefore = flagCount;
        applyStimulus(8'h3C, 1'b1, BAUD_DIV);
        idleLine(BAUD_DIV);
        checkOutput("t5_flags", 32'(flagCount - flagsBefore), 32'd1);
        checkOutput("t5_data", 32'(dataReceived), 32'h3C);

        // Test 6: 0x00, 0xFF, 0x80 at +2 % and at -2 % line rate
        flagsBefore = flagCount;
        errsBefore  = errCount;
        qBase       = rxQ.size();
        applyStimulus(8'h00, 1'b1, BIT_FAST);
        idleLine(BAUD_DIV);
        applyStimulus(8'hFF, 1'b1, BIT_FAST);
        idleLine(BAUD_DIV);
        applyStimulus(8'h80, 1'b1, BIT_FAST);
        idleLine(BAUD_DIV);
        applyStimulus(8'h00, 1'b1, BIT_SLOW);
        idleLine(BAUD_DIV);
        applyStimulus(8'hFF, 1'b1, BIT_SLOW);
        idleLine(BAUD_DIV);
        applyStimulus(8'h80, 1'b1, BIT_SLOW);
        idleLine(BAUD_DIV);
        checkOutput("t6_flags", 32'(flagCount - flagsBefore), 32'd6);
        checkOutput("t6_errs", 32'(errCount - errsBefore), 32'd0);
        checkOutput("t6_fast_00", 32'(rxQ.size() > qBase     ? rxQ[qBase]     : 8'hxx), 32'h00);
        checkOutput("t6_fast_FF", 32'(rxQ.size() > qBase + 1 ? rxQ[qBase + 1] : 8'hxx), 32'hFF);
        checkOutput("t6_fast_80", 32'(rxQ.size() > qBase + 2 ? rxQ[qBase + 2] : 8'hxx), 32'h80);
        checkOutput("t6_slow_00", 32'(rxQ.size() > qBase + 3 ? rxQ[qBase + 3] : 8'hxx), 32'h00);
        checkOutput("t6_slow_FF", 32'(rxQ.size() > qBase + 4 ? rxQ[qBase + 4] : 8'hxx), 32'hFF);
        checkOutput("t6_slow_80", 32'(rxQ.size() > qBase + 5 ? rxQ[qBase + 5] : 8'hxx), 32'h80);

        // Pulses never overlapped or came in consecutive cycles
        checkOutput("pulse_exclusive", 32'(pulseViol), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
